// File: rtl/mcu_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcu_timer_pkg
// Description : Register map, CTRL bit positions and run state for mcu_timer.
// Revision    : 1.0
// ============================================================================
package mcu_timer_pkg;

    localparam logic [2:0] TMR_CTRL_OFS   = 3'd0;
    localparam logic [2:0] TMR_PRESC_OFS  = 3'd1;
    localparam logic [2:0] TMR_CMP_OFS    = 3'd2;
    localparam logic [2:0] TMR_COUNT_OFS  = 3'd3;
    localparam logic [2:0] TMR_STATUS_OFS = 3'd4;

    localparam int TMR_CTRL_EN_BIT = 0;
    localparam int TMR_CTRL_AR_BIT = 1;
    localparam int TMR_CTRL_IE_BIT = 2;

    typedef enum logic [0:0] {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } tmr_state_t;

endpackage
`default_nettype wire

// File: rtl/tmr_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tmr_prescaler
// Description : Divides the clock by period+1, producing a one-cycle tick.
// Revision    : 1.0
// ============================================================================
module tmr_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear,
    input  logic [15:0] period,
    output logic        tick
);

    logic [15:0] r_cnt;

    assign tick = enable & (r_cnt == period);

    always_ff @(posedge clk) begin
        if (rst || clear || !enable) begin
            r_cnt <= 16'd0;
        end else if (r_cnt == period) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mcu_timer.sv
`default_nettype none
// ============================================================================
// Module      : mcu_timer
// Description : Memory-mapped 32-bit timer/compare peripheral with match IRQ.
// Revision    : 1.0
// ============================================================================
module mcu_timer
    import mcu_timer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hFFFF_FF00
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic                  bus_wr_en,
    input  logic [DATA_WIDTH-1:0] bus_wr_data,
    output logic                  bus_sel,
    output logic [DATA_WIDTH-1:0] bus_rd_data,
    output logic                  tmr_irq
);

    tmr_state_t            r_state;
    tmr_state_t            w_state_next;
    logic                  r_ar;
    logic                  r_ie;
    logic [15:0]           r_presc;
    logic [DATA_WIDTH-1:0] r_cmp;
    logic [DATA_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] w_count_next;
    logic                  r_match;
    logic                  w_match_next;

    logic [2:0]            w_ofs;
    logic                  w_we;
    logic                  w_wr_ctrl;
    logic                  w_wr_presc;
    logic                  w_wr_cmp;
    logic                  w_wr_count;
    logic                  w_wr_status;
    logic                  w_tick;
    logic                  w_cmp_hit;
    logic                  w_presc_clear;
    logic [DATA_WIDTH-1:0] w_rd_mux;
    logic                  w_unused;

    assign bus_sel     = (bus_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
    assign w_ofs       = bus_addr[4:2];
    assign w_unused    = &{1'b0, bus_addr[1:0]};
    assign w_we        = bus_sel & bus_wr_en;
    assign w_wr_ctrl   = w_we && (w_ofs == TMR_CTRL_OFS);
    assign w_wr_presc  = w_we && (w_ofs == TMR_PRESC_OFS);
    assign w_wr_cmp    = w_we && (w_ofs == TMR_CMP_OFS);
    assign w_wr_count  = w_we && (w_ofs == TMR_COUNT_OFS);
    assign w_wr_status = w_we && (w_ofs == TMR_STATUS_OFS);
    assign w_cmp_hit   = (r_count == r_cmp);

    // Restart the divider on a PRESC write or a stopped-to-running CTRL write.
    assign w_presc_clear = w_wr_presc |
                           (w_wr_ctrl & bus_wr_data[TMR_CTRL_EN_BIT] & (r_state == STOPPED));

    tmr_prescaler u_prescaler (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .enable (r_state == RUNNING),
        .clear  (w_presc_clear),
        .period (r_presc),
        .tick   (w_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= STOPPED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_match_next = r_match;
        if (w_wr_ctrl) begin
            w_state_next = bus_wr_data[TMR_CTRL_EN_BIT] ? RUNNING : STOPPED;
        end else if (w_tick && w_cmp_hit && !r_ar) begin
            w_state_next = STOPPED;
        end
        if (w_wr_count) begin
            w_count_next = bus_wr_data;
        end else if (w_tick) begin
            if (w_cmp_hit) begin
                w_count_next = r_ar ? '0 : r_count;
            end else begin
                w_count_next = r_count + 1'b1;
            end
        end
        // A match on this edge outranks a simultaneous write-1-to-clear.
        if (w_tick && w_cmp_hit) begin
            w_match_next = 1'b1;
        end else if (w_wr_status && bus_wr_data[0]) begin
            w_match_next = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_ar    <= 1'b0;
            r_ie    <= 1'b0;
            r_presc <= 16'd0;
            r_cmp   <= '1;
            r_count <= '0;
            r_match <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ar <= bus_wr_data[TMR_CTRL_AR_BIT];
                r_ie <= bus_wr_data[TMR_CTRL_IE_BIT];
            end
            if (w_wr_presc) begin
                r_presc <= bus_wr_data[15:0];
            end
            if (w_wr_cmp) begin
                r_cmp <= bus_wr_data;
            end
            r_count <= w_count_next;
            r_match <= w_match_next;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_ofs)
            TMR_CTRL_OFS: begin
                w_rd_mux[TMR_CTRL_EN_BIT] = (r_state == RUNNING);
                w_rd_mux[TMR_CTRL_AR_BIT] = r_ar;
                w_rd_mux[TMR_CTRL_IE_BIT] = r_ie;
            end
            TMR_PRESC_OFS:  w_rd_mux[15:0] = r_presc;
            TMR_CMP_OFS:    w_rd_mux       = r_cmp;
            TMR_COUNT_OFS:  w_rd_mux       = r_count;
            TMR_STATUS_OFS: w_rd_mux[0]    = r_match;
            default:        w_rd_mux       = '0;
        endcase
    end

    assign bus_rd_data = bus_sel ? w_rd_mux : '0;
    assign tmr_irq     = r_match & r_ie;

endmodule
`default_nettype wire

// File: tb/tb_mcu_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcu_timer
// Description : Directed self-checking bench for mcu_timer with expected-value queue.
// Revision    : 1.0
// ============================================================================
module tb_mcu_timer;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_PRESC  = BASE + 32'h04;
    localparam logic [31:0] A_CMP    = BASE + 32'h08;
    localparam logic [31:0] A_COUNT  = BASE + 32'h0C;
    localparam logic [31:0] A_STATUS = BASE + 32'h10;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] bus_addr;
    logic        bus_wr_en;
    logic [31:0] bus_wr_data;
    logic        bus_sel;
    logic [31:0] bus_rd_data;
    logic        tmr_irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    mcu_timer #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (BASE)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .bus_addr    (bus_addr),
        .bus_wr_en   (bus_wr_en),
        .bus_wr_data (bus_wr_data),
        .bus_sel     (bus_sel),
        .bus_rd_data (bus_rd_data),
        .tmr_irq     (tmr_irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic compare_pop(input string tag, input logic [31:0] obs);
        logic [31:0] expv;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s observed %h expected <empty queue>", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", tag, obs, expv);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus_addr    = addr;
        bus_wr_data = data;
        bus_wr_en   = 1'b1;
        @(posedge sys_clk);
        #1;
        bus_wr_en   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] expv);
        bus_addr = addr;
        exp_q.push_back(expv);
        #1;
        compare_pop(tag, bus_rd_data);
    endtask

    task automatic chk_irq(input string tag, input logic expv);
        exp_q.push_back({31'd0, expv});
        compare_pop(tag, {31'd0, tmr_irq});
    endtask

    task automatic chk_sel(input string tag, input logic [31:0] addr, input logic expv);
        bus_addr = addr;
        exp_q.push_back({31'd0, expv});
        #1;
        compare_pop(tag, {31'd0, bus_sel});
    endtask

    initial begin
        sys_rst     = 1'b1;
        bus_addr    = 32'd0;
        bus_wr_en   = 1'b0;
        bus_wr_data = 32'd0;
        step(2);
        sys_rst = 1'b0;

        // Reset discards a previously written COUNT
        wr(A_COUNT, 32'd5);
        rd("pre_rst_count", A_COUNT, 32'd5);
        sys_rst = 1'b1;
        step(2);
        rd("rst_ctrl",   A_CTRL,   32'd0);
        rd("rst_presc",  A_PRESC,  32'd0);
        rd("rst_cmp",    A_CMP,    32'hFFFF_FFFF);
        rd("rst_count",  A_COUNT,  32'd0);
        rd("rst_status", A_STATUS, 32'd0);
        chk_irq("rst_irq", 1'b0);
        sys_rst = 1'b0;
        step(1);

        // Periodic auto-reload: one step every 4 cycles, match at 12
        wr(A_PRESC, 32'd3);
        wr(A_CMP,   32'd2);
        wr(A_CTRL,  32'd7);
        rd("ar_k0_count", A_COUNT, 32'd0);
        step(3);
        rd("ar_k3_count", A_COUNT, 32'd0);
        step(1);
        rd("ar_k4_count", A_COUNT, 32'd1);
        step(4);
        rd("ar_k8_count", A_COUNT, 32'd2);
        chk_irq("ar_k8_irq", 1'b0);
        step(3);
        rd("ar_k11_status", A_STATUS, 32'd0);
        step(1);
        rd("ar_k12_status", A_STATUS, 32'd1);
        rd("ar_k12_count",  A_COUNT,  32'd0);
        chk_irq("ar_k12_irq", 1'b1);
        wr(A_STATUS, 32'd1);
        chk_irq("ar_w1c_irq", 1'b0);
        rd("ar_w1c_status", A_STATUS, 32'd0);

        // COUNT write on a tick edge (tick at k=16)
        step(2);
        wr(A_COUNT, 32'd100);
        rd("coll_count", A_COUNT, 32'd100);
        wr(A_CTRL, 32'd0);

        // W1C on the match edge leaves MATCH set
        wr(A_COUNT, 32'd0);
        wr(A_CMP,   32'd1);
        wr(A_PRESC, 32'd0);
        wr(A_CTRL,  32'd7);
        step(1);
        wr(A_STATUS, 32'd1);
        rd("coll_w1c_status", A_STATUS, 32'd1);
        chk_irq("coll_w1c_irq", 1'b1);
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'd1);
        rd("clr_status", A_STATUS, 32'd0);

        // One-shot: match at cycle 5, EN self-clears, COUNT holds CMP
        wr(A_COUNT, 32'd0);
        wr(A_CMP,   32'd4);
        wr(A_CTRL,  32'd1);
        step(4);
        rd("os_k4_count",  A_COUNT,  32'd4);
        rd("os_k4_status", A_STATUS, 32'd0);
        rd("os_k4_ctrl",   A_CTRL,   32'd1);
        step(1);
        rd("os_k5_status", A_STATUS, 32'd1);
        rd("os_k5_ctrl",   A_CTRL,   32'd0);
        chk_irq("os_k5_irq", 1'b0);
        step(3);
        rd("os_hold_count", A_COUNT, 32'd4);

        // Wrap from all-ones to zero without a match
        wr(A_STATUS, 32'd1);
        wr(A_COUNT, 32'hFFFF_FFFF);
        wr(A_CMP,   32'd7);
        wr(A_CTRL,  32'd1);
        rd("wrap_k0_count", A_COUNT, 32'hFFFF_FFFF);
        step(1);
        rd("wrap_k1_count",  A_COUNT,  32'd0);
        rd("wrap_k1_status", A_STATUS, 32'd0);
        wr(A_CTRL, 32'd0);
        wr(A_COUNT, 32'd3);

        // Address decode
        rd("dec_reserved", BASE + 32'h18, 32'd0);
        chk_sel("dec_sel_in", BASE + 32'h18, 1'b1);
        chk_sel("dec_sel_out", BASE + 32'h20, 1'b0);
        rd("dec_out_rd", BASE + 32'h2C, 32'd0);
        wr(BASE + 32'h2C, 32'd55);
        wr(BASE + 32'h20, 32'd7);
        rd("dec_out_count", A_COUNT, 32'd3);
        rd("dec_out_ctrl",  A_CTRL,  32'd0);
        rd("dec_unal_rd", BASE + 32'h0E, 32'd3);
        wr(BASE + 32'h0E, 32'd9);
        rd("dec_unal_wr", A_COUNT, 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
